bd_fetch_sequencer: RTL and testbench

- Downstream consumer of the buffer-descriptor (BD) RAM in the DMA controller.
- On request, issues four back-to-back reads for one descriptor and absorbs the fixed RAM read latency.
- Assembles the config / source / destination / byte-count words into one record and presents it to the channel engine over a valid/ready handshake.
- Screens ECC flags returned with each word and validity fields in the assembled record.

---
 rtl/bd_fetch_sequencer_if.sv | 37 +++
 rtl/bd_fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bd_fetch_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bd_fetch_sequencer_if.sv
// BD fetch sequencer bus: BD RAM read port, fetch request and descriptor handoff.
// The sequencer uses the master view; the RAM and channel engine side uses slave.
interface bd_fetch_sequencer_if #(
    parameter int NUM_INT_BDS_WIDTH = 2
);
    logic                           fetchReq;
    logic [NUM_INT_BDS_WIDTH-1:0]   fetchBdNum;
    logic                           fetchRdy;
    logic                           bdRdEn;
    logic [NUM_INT_BDS_WIDTH+1:0]   bdRdAddr;
    logic [31:0]                    bdRdData;
    logic                           bdEccSb;
    logic                           bdEccDb;
    logic                           bdValid;
    logic                           bdReady;
    logic [NUM_INT_BDS_WIDTH-1:0]   bdNumOut;
    logic [31:0]                    bdConfig;
    logic [31:0]                    bdSrcAddr;
    logic [31:0]                    bdDstAddr;
    logic [31:0]                    bdByteCnt;
    logic                           bdInvalid;
    logic                           bdEccErr;
    logic [7:0]                     sbErrCnt;
    logic                           clrErrCnt;

    modport master (
        input  fetchReq, fetchBdNum, bdRdData, bdEccSb, bdEccDb, bdReady, clrErrCnt,
        output fetchRdy, bdRdEn, bdRdAddr, bdValid, bdNumOut, bdConfig, bdSrcAddr,
               bdDstAddr, bdByteCnt, bdInvalid, bdEccErr, sbErrCnt
    );

    modport slave (
        output fetchReq, fetchBdNum, bdRdData, bdEccSb, bdEccDb, bdReady, clrErrCnt,
        input  fetchRdy, bdRdEn, bdRdAddr, bdValid, bdNumOut, bdConfig, bdSrcAddr,
               bdDstAddr, bdByteCnt, bdInvalid, bdEccErr, sbErrCnt
    );
endinterface

// File: rtl/bd_fetch_sequencer.sv
// BD fetch sequencer: reads one 4-word buffer descriptor from the BD RAM,
// screens ECC and validity, and hands the record to the channel engine.
//
// state   | meaning
// IDLE    | ready for a fetch request
// ISSUE   | four back-to-back RAM reads being issued
// DRAIN   | waiting for the word 3 return, then judging the record
// PRESENT | record held on bdValid until bdReady
module bd_fetch_sequencer #(
    parameter int NUM_INT_BDS_WIDTH = 2,
    parameter int RD_LAT            = 2
) (
    input logic                  clock,
    input logic                  resetn,
    bd_fetch_sequencer_if.master bus
);
    localparam int AW = NUM_INT_BDS_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, PRESENT} state_t;

    state_t                       state_q, state_d;
    logic [NUM_INT_BDS_WIDTH-1:0] bd_num_q, bd_num_d;
    logic                         fetch_rdy_q, fetch_rdy_d;
    logic                         rd_en_q, rd_en_d;
    logic [AW-1:0]                rd_addr_q, rd_addr_d;
    logic                         valid_q, valid_d;
    logic                         invalid_q, invalid_d;
    logic                         ecc_err_q, ecc_err_d;
    logic                         db_sticky_q, db_sticky_d;

    logic [RD_LAT-1:0]            pipe_en_q;
    logic [1:0]                   pipe_idx_q [RD_LAT];
    logic [31:0]                  word_q [4];
    logic [7:0]                   sb_cnt_q;

    logic                         cap_en;
    logic [1:0]                   cap_idx;
    logic                         last_cap;

    assign cap_en   = pipe_en_q[RD_LAT-1];
    assign cap_idx  = pipe_idx_q[RD_LAT-1];
    assign last_cap = cap_en && (cap_idx == 2'd3);

    always_comb begin
        state_d     = state_q;
        bd_num_d    = bd_num_q;
        fetch_rdy_d = fetch_rdy_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        valid_d     = valid_q;
        invalid_d   = 1'b0;
        ecc_err_d   = 1'b0;
        db_sticky_d = db_sticky_q | (cap_en & bus.bdEccDb);
        case (state_q)
            IDLE: begin
                if (bus.fetchReq) begin
                    bd_num_d    = bus.fetchBdNum;
                    fetch_rdy_d = 1'b0;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = {bus.fetchBdNum, 2'd0};
                    db_sticky_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (rd_addr_q[1:0] == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = {bd_num_q, rd_addr_q[1:0] + 2'd1};
                end
            end
            DRAIN: begin
                // Word 3 is judged as it arrives so bdValid follows its capture directly.
                if (last_cap) begin
                    if (db_sticky_q || bus.bdEccDb) begin
                        ecc_err_d   = 1'b1;
                        fetch_rdy_d = 1'b1;
                        state_d     = IDLE;
                    end else if (!word_q[0][0] || (bus.bdRdData == 32'd0)) begin
                        invalid_d   = 1'b1;
                        fetch_rdy_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        valid_d = 1'b1;
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (bus.bdReady) begin
                    valid_d     = 1'b0;
                    fetch_rdy_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                fetch_rdy_d = 1'b1;
                valid_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bd_num_q    <= '0;
            fetch_rdy_q <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            valid_q     <= 1'b0;
            invalid_q   <= 1'b0;
            ecc_err_q   <= 1'b0;
            db_sticky_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bd_num_q    <= bd_num_d;
            fetch_rdy_q <= fetch_rdy_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            valid_q     <= valid_d;
            invalid_q   <= invalid_d;
            ecc_err_q   <= ecc_err_d;
            db_sticky_q <= db_sticky_d;
        end
    end

    // Read-latency shadow of the issued reads; clearing it on reset drops in-flight returns.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_en_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= 2'd0;
            for (int i = 0; i < 4; i++) word_q[i] <= 32'd0;
            sb_cnt_q <= 8'd0;
        end else begin
            pipe_en_q[0]  <= rd_en_q;
            pipe_idx_q[0] <= rd_addr_q[1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_en_q[i]  <= pipe_en_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
            if (cap_en) word_q[cap_idx] <= bus.bdRdData;
            if (bus.clrErrCnt)
                sb_cnt_q <= 8'd0;
            else if (cap_en && bus.bdEccSb && !bus.bdEccDb && (sb_cnt_q != 8'hFF))
                sb_cnt_q <= sb_cnt_q + 8'd1;
        end
    end

    assign bus.fetchRdy  = fetch_rdy_q;
    assign bus.bdRdEn    = rd_en_q;
    assign bus.bdRdAddr  = rd_addr_q;
    assign bus.bdValid   = valid_q;
    assign bus.bdNumOut  = bd_num_q;
    assign bus.bdConfig  = word_q[0];
    assign bus.bdSrcAddr = word_q[1];
    assign bus.bdDstAddr = word_q[2];
    assign bus.bdByteCnt = word_q[3];
    assign bus.bdInvalid = invalid_q;
    assign bus.bdEccErr  = ecc_err_q;
    assign bus.sbErrCnt  = sb_cnt_q;
endmodule

// File: tb/tb_bd_fetch_sequencer.sv
// Bench for bd_fetch_sequencer: BD RAM model with ECC injection, a per-fetch
// timeline model checked every cycle, and directed literal checks.
module tb_bd_fetch_sequencer;
    localparam int RD_LAT = 2;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    bd_fetch_sequencer_if #(.NUM_INT_BDS_WIDTH(2)) bus ();

    bd_fetch_sequencer #(.NUM_INT_BDS_WIDTH(2), .RD_LAT(RD_LAT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // BD RAM with fixed read latency and per-address ECC flag injection
    logic [31:0] mem [16];
    bit          sb_inj [16];
    bit          db_inj [16];
    logic [RD_LAT-1:0] ram_en = '0;
    logic [3:0]        ram_addr [RD_LAT];

    always @(posedge clock) begin
        ram_en[0]   <= bus.bdRdEn;
        ram_addr[0] <= bus.bdRdAddr;
        for (int i = 1; i < RD_LAT; i++) begin
            ram_en[i]   <= ram_en[i-1];
            ram_addr[i] <= ram_addr[i-1];
        end
    end

    assign bus.bdRdData = ram_en[RD_LAT-1] ? mem[ram_addr[RD_LAT-1]] : 32'hDEAD_BEEF;
    assign bus.bdEccSb  = ram_en[RD_LAT-1] ? sb_inj[ram_addr[RD_LAT-1]] : 1'b0;
    assign bus.bdEccDb  = ram_en[RD_LAT-1] ? db_inj[ram_addr[RD_LAT-1]] : 1'b0;

    // Timeline model: a fetch accepted at edge T reads in cycles T+1..T+4, word j is
    // captured at edge T+1+j+RD_LAT, and the outcome shows in cycle T+RD_LAT+5.
    int          cyc = 0, m_T = 0, m_num = 0, m_cnt = 0, e_addr = 0;
    bit          m_busy = 0, e_rdy = 1, e_en = 0, e_valid = 0, e_inv = 0, e_ecc = 0;
    bit          m_dbany = 0, m_bad = 0;
    bit          m_sb [4];
    bit          m_db [4];
    logic [31:0] m_w [4];

    always @(posedge clock or negedge resetn) begin
        int  kc, kn;
        bit  inc;
        if (!resetn) begin
            cyc = 0; m_busy = 0; m_cnt = 0;
            e_rdy = 1; e_en = 0; e_valid = 0; e_inv = 0; e_ecc = 0; e_addr = 0;
        end else begin
            cyc++;
            kc    = cyc - m_T;
            e_inv = 0;
            e_ecc = 0;
            inc   = 0;
            if (m_busy)
                for (int j = 0; j < 4; j++)
                    if (kc == j + RD_LAT + 1 && m_sb[j] && !m_db[j]) inc = 1;
            if (bus.clrErrCnt) m_cnt = 0;
            else if (inc && m_cnt < 255) m_cnt++;
            if (m_busy) begin
                if (e_valid) begin
                    if (bus.bdReady) begin
                        e_valid = 0;
                        m_busy  = 0;
                    end
                end else if (kc == RD_LAT + 4) begin
                    if (m_dbany) begin e_ecc = 1; m_busy = 0; end
                    else if (m_bad) begin e_inv = 1; m_busy = 0; end
                    else e_valid = 1;
                end
            end else if (bus.fetchReq) begin
                m_busy  = 1;
                m_T     = cyc;
                m_num   = int'(bus.fetchBdNum);
                m_dbany = 0;
                for (int j = 0; j < 4; j++) begin
                    m_w[j]  = mem[m_num*4 + j];
                    m_sb[j] = sb_inj[m_num*4 + j];
                    m_db[j] = db_inj[m_num*4 + j];
                    if (m_db[j]) m_dbany = 1;
                end
                m_bad = !m_w[0][0] || (m_w[3] == 32'd0);
            end
            kn     = cyc + 1 - m_T;
            e_rdy  = !m_busy;
            e_en   = m_busy && kn >= 1 && kn <= 4;
            e_addr = m_num*4 + kn - 1;
        end
    end

    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            chk("fetchRdy",  32'(bus.fetchRdy),  32'(e_rdy));
            chk("bdRdEn",    32'(bus.bdRdEn),    32'(e_en));
            if (e_en) chk("bdRdAddr", 32'(bus.bdRdAddr), e_addr);
            chk("bdValid",   32'(bus.bdValid),   32'(e_valid));
            chk("bdInvalid", 32'(bus.bdInvalid), 32'(e_inv));
            chk("bdEccErr",  32'(bus.bdEccErr),  32'(e_ecc));
            chk("sbErrCnt",  32'(bus.sbErrCnt),  m_cnt);
            if (e_valid) begin
                chk("bdNumOut",  32'(bus.bdNumOut), m_num);
                chk("bdConfig",  bus.bdConfig,  m_w[0]);
                chk("bdSrcAddr", bus.bdSrcAddr, m_w[1]);
                chk("bdDstAddr", bus.bdDstAddr, m_w[2]);
                chk("bdByteCnt", bus.bdByteCnt, m_w[3]);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    // Returns at the negedge of cycle T+1, where T is the accepting edge.
    task automatic start_fetch(input int num);
        int n = 0;
        while (bus.fetchRdy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("fetchRdy_timeout", 32'd0, 32'd1);
        bus.fetchReq   = 1'b1;
        bus.fetchBdNum = 2'(num);
        @(posedge clock);
        tick();
        bus.fetchReq = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fetchRdy"}, 32'(bus.fetchRdy),  32'd1);
        chk({tag, "_bdRdEn"},   32'(bus.bdRdEn),    32'd0);
        chk({tag, "_bdRdAddr"}, 32'(bus.bdRdAddr),  32'd0);
        chk({tag, "_bdValid"},  32'(bus.bdValid),   32'd0);
        chk({tag, "_bdInval"},  32'(bus.bdInvalid), 32'd0);
        chk({tag, "_bdEccErr"}, 32'(bus.bdEccErr),  32'd0);
        chk({tag, "_sbErrCnt"}, 32'(bus.sbErrCnt),  32'd0);
        chk({tag, "_bdConfig"}, bus.bdConfig,       32'd0);
        chk({tag, "_bdByteCnt"}, bus.bdByteCnt,     32'd0);
        chk({tag, "_bdNumOut"}, 32'(bus.bdNumOut),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int addr_lit [4];
        addr_lit = '{8, 9, 10, 11};
        for (int i = 0; i < 16; i++) begin
            sb_inj[i] = 0;
            db_inj[i] = 0;
        end
        mem[0]  = 32'h0000_0003; mem[1]  = 32'hA000_0000; mem[2]  = 32'hB000_0000; mem[3]  = 32'h0000_0040;
        mem[4]  = 32'h0000_0000; mem[5]  = 32'h1111_0000; mem[6]  = 32'h2222_0000; mem[7]  = 32'h0000_0010;
        mem[8]  = 32'h0000_0001; mem[9]  = 32'h1000_0000; mem[10] = 32'h2000_0000; mem[11] = 32'h0000_0100;
        mem[12] = 32'h0000_0003; mem[13] = 32'h3000_0000; mem[14] = 32'h4000_0000; mem[15] = 32'h0000_0000;

        bus.fetchReq   = 1'b0;
        bus.fetchBdNum = 2'd0;
        bus.bdReady    = 1'b0;
        bus.clrErrCnt  = 1'b0;
        resetn = 1'b1;
        #3 resetn = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        resetn = 1'b1;
        tick();

        // BD2 with a stalled consumer; a stray request mid-fetch is ignored
        start_fetch(2);
        chk("t1_addr0", 32'(bus.bdRdAddr), addr_lit[0]);
        tick();
        chk("t1_addr1", 32'(bus.bdRdAddr), addr_lit[1]);
        bus.fetchReq = 1'b1; bus.fetchBdNum = 2'd0;
        tick();
        bus.fetchReq = 1'b0;
        chk("t1_addr2", 32'(bus.bdRdAddr), addr_lit[2]);
        tick();
        chk("t1_addr3", 32'(bus.bdRdAddr), addr_lit[3]);
        tick();
        chk("t1_rden_off", 32'(bus.bdRdEn), 32'd0);
        tick();
        chk("t1_valid_c6", 32'(bus.bdValid), 32'd0);
        tick();
        chk("t1_valid_c7", 32'(bus.bdValid), 32'd1);
        chk("t1_cfg", bus.bdConfig,  32'h0000_0001);
        chk("t1_src", bus.bdSrcAddr, 32'h1000_0000);
        chk("t1_dst", bus.bdDstAddr, 32'h2000_0000);
        chk("t1_cnt", bus.bdByteCnt, 32'h0000_0100);
        chk("t1_num", 32'(bus.bdNumOut), 32'd2);
        repeat (5) begin
            tick();
            chk("t1_hold_valid", 32'(bus.bdValid), 32'd1);
            chk("t1_hold_src", bus.bdSrcAddr, 32'h1000_0000);
        end
        bus.bdReady = 1'b1;
        tick();
        chk("t1_valid_drop", 32'(bus.bdValid), 32'd0);
        chk("t1_rdy_back", 32'(bus.fetchRdy), 32'd1);

        // bdReady tied high: completes in the bdValid cycle
        start_fetch(0);
        repeat (6) tick();
        chk("t2_valid_c7", 32'(bus.bdValid), 32'd1);
        chk("t2_cfg", bus.bdConfig, 32'h0000_0003);
        tick();
        chk("t2_valid_c8", 32'(bus.bdValid), 32'd0);
        chk("t2_rdy_c8", 32'(bus.fetchRdy), 32'd1);

        // Double-bit error on word 1 aborts the fetch
        db_inj[1] = 1;
        start_fetch(0);
        repeat (6) tick();
        chk("t3_ecc_c7", 32'(bus.bdEccErr), 32'd1);
        chk("t3_valid_c7", 32'(bus.bdValid), 32'd0);
        tick();
        chk("t3_ecc_c8", 32'(bus.bdEccErr), 32'd0);
        chk("t3_rdy_c8", 32'(bus.fetchRdy), 32'd1);
        db_inj[1] = 0;

        // Single-bit corrections on words 0 and 3
        sb_inj[8] = 1; sb_inj[11] = 1;
        start_fetch(2);
        repeat (3) tick();
        chk("t4_cnt_c4", 32'(bus.sbErrCnt), 32'd1);
        repeat (3) tick();
        chk("t4_cnt_c7", 32'(bus.sbErrCnt), 32'd2);
        chk("t4_valid_c7", 32'(bus.bdValid), 32'd1);
        sb_inj[8] = 0; sb_inj[11] = 0;

        // Drive the counter to 254, then saturate
        for (int i = 0; i < 4; i++) sb_inj[i] = 1;
        for (int f = 0; f < 63; f++) start_fetch(0);
        repeat (7) tick();
        chk("t5_cnt_254", 32'(bus.sbErrCnt), 32'd254);
        sb_inj[3] = 0;
        start_fetch(0);
        repeat (7) tick();
        chk("t5_cnt_sat", 32'(bus.sbErrCnt), 32'd255);

        // Clear coincident with a word 0 SB capture
        sb_inj[1] = 0; sb_inj[2] = 0;
        start_fetch(0);
        repeat (2) tick();
        bus.clrErrCnt = 1'b1;
        tick();
        bus.clrErrCnt = 1'b0;
        chk("t6_clr_win", 32'(bus.sbErrCnt), 32'd0);
        sb_inj[0] = 0;
        repeat (4) tick();

        // Rejected descriptors: config[0]==0, then byte count 0
        start_fetch(1);
        repeat (6) tick();
        chk("t7_inv_c7", 32'(bus.bdInvalid), 32'd1);
        chk("t7_valid_c7", 32'(bus.bdValid), 32'd0);
        tick();
        chk("t7_inv_c8", 32'(bus.bdInvalid), 32'd0);
        start_fetch(3);
        repeat (6) tick();
        chk("t8_inv_c7", 32'(bus.bdInvalid), 32'd1);
        chk("t8_valid_c7", 32'(bus.bdValid), 32'd0);

        // Reset mid-fetch: asserted in cycle T+3, released in cycle T+5
        start_fetch(2);
        repeat (2) tick();
        #2 resetn = 1'b0;
        #1 check_reset_vals("t9_rst");
        repeat (2) tick();
        resetn = 1'b1;
        repeat (8) begin
            tick();
            chk("t9_no_valid", 32'(bus.bdValid), 32'd0);
            chk("t9_no_inv", 32'(bus.bdInvalid), 32'd0);
        end

        // Recovery fetch
        start_fetch(0);
        repeat (6) tick();
        chk("t10_valid_c7", 32'(bus.bdValid), 32'd1);
        chk("t10_cfg", bus.bdConfig, 32'h0000_0003);
        chk("t10_cnt", bus.bdByteCnt, 32'h0000_0040);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
